// File: rtl/module_display.sv
// Four-digit multiplexed traffic countdown display with two-road lamp decode.
// Loads are converted to BCD serially and committed atomically; later Loads queue behind.
module module_display #(
  parameter int          SCAN_DIV  = 4,
  parameter int          BLINK_DIV = 5,
  parameter logic [7:0]  REDL      = 8'd1,
  parameter logic [7:0]  GREENL    = 8'd2,
  parameter logic [7:0]  YELLOWL   = 8'd3,
  parameter logic [7:0]  ONLINEL   = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Load,
  input  logic [15:0] MainTime,
  input  logic [15:0] SubTime,
  input  logic [7:0]  MainColor,
  input  logic [7:0]  SubColor,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [2:0]  MainLed,
  output logic [2:0]  SubLed,
  output logic        Busy
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV_MAIN = 2'd1,
    CONV_SUB  = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  function automatic logic [6:0] sat99(input logic [15:0] t);
    return (t > 16'd99) ? 7'd99 : t[6:0];
  endfunction

  // One double-dabble step on {tens, ones, remaining binary bits}.
  function automatic logic [14:0] dabble(input logic [14:0] s);
    logic [14:0] r;
    r = s;
    if (r[10:7] >= 4'd5) r[10:7] = r[10:7] + 4'd3;
    else                 r[10:7] = r[10:7];
    if (r[14:11] >= 4'd5) r[14:11] = r[14:11] + 4'd3;
    else                  r[14:11] = r[14:11];
    return {r[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d, input logic blank);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return blank ? 7'h7F : p;
  endfunction

  function automatic logic [2:0] lamp(input logic [7:0] code, input logic phase);
    logic [2:0] l;
    case (code)
      REDL:    l = 3'b100;
      GREENL:  l = 3'b001;
      YELLOWL: l = 3'b010;
      ONLINEL: l = phase ? 3'b010 : 3'b000;
      default: l = 3'b000;
    endcase
    return l;
  endfunction

  state_t        state_q;
  logic          pending_q, busy_q;
  logic [2:0]    step_q;
  logic [14:0]   sh_q;
  logic [6:0]    work_sub_q, shd_main_q, shd_sub_q;
  logic [7:0]    work_mc_q, work_sc_q, shd_mc_q, shd_sc_q;
  logic [7:0]    main_bcd_q, sub_bcd_q, mcol_q, scol_q;
  logic [15:0]   disp_q;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [2:0]    mled_q, mled_d, sled_q, sled_d;
  logic [3:0]    dig_s;
  logic [14:0]   dab_s;

  // Free-running scan/blink next state and the display words they select.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SW'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = {SW{1'b0}};
      idx_d      = idx_q - 2'd1;
    end else begin
      idx_d      = idx_q;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = {BW{1'b0}};
      blink_d     = ~blink_q;
    end else begin
      blink_d     = blink_q;
    end
    dig_s  = disp_q[{idx_d, 2'b00} +: 4];
    seg_d  = seg_of(dig_s, idx_d[0] && (dig_s == 4'd0));
    an_d   = ~(4'b0001 << idx_d);
    mled_d = lamp(mcol_q, blink_d);
    sled_d = lamp(scol_q, blink_d);
    dab_s  = dabble(sh_q);
  end

  // Conversion FSM, load shadowing, committed display state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= 3'd0;
      sh_q        <= 15'd0;
      work_sub_q  <= 7'd0;
      work_mc_q   <= 8'd0;
      work_sc_q   <= 8'd0;
      shd_main_q  <= 7'd0;
      shd_sub_q   <= 7'd0;
      shd_mc_q    <= 8'd0;
      shd_sc_q    <= 8'd0;
      main_bcd_q  <= 8'd0;
      sub_bcd_q   <= 8'd0;
      disp_q      <= 16'd0;
      mcol_q      <= 8'd0;
      scol_q      <= 8'd0;
      scan_cnt_q  <= {SW{1'b0}};
      idx_q       <= 2'd3;
      blink_cnt_q <= {BW{1'b0}};
      blink_q     <= 1'b0;
      seg_q       <= 7'h7F;
      an_q        <= 4'b0111;
      mled_q      <= 3'b000;
      sled_q      <= 3'b000;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      mled_q      <= mled_d;
      sled_q      <= sled_d;

      // Only the most recent Load during a conversion survives in the shadow.
      if (Load && ((state_q == CONV_MAIN) || (state_q == CONV_SUB))) begin
        shd_main_q <= sat99(MainTime);
        shd_sub_q  <= sat99(SubTime);
        shd_mc_q   <= MainColor;
        shd_sc_q   <= SubColor;
        pending_q  <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (Load) begin
            sh_q       <= {8'd0, sat99(MainTime)};
            work_sub_q <= sat99(SubTime);
            work_mc_q  <= MainColor;
            work_sc_q  <= SubColor;
            step_q     <= 3'd0;
            state_q    <= CONV_MAIN;
            busy_q     <= 1'b1;
          end else begin
            busy_q     <= 1'b0;
          end
        end
        CONV_MAIN: begin
          busy_q <= 1'b1;
          if (step_q == 3'd6) begin
            main_bcd_q <= dab_s[14:7];
            sh_q       <= {8'd0, work_sub_q};
            step_q     <= 3'd0;
            state_q    <= CONV_SUB;
          end else begin
            sh_q       <= dab_s;
            step_q     <= step_q + 3'd1;
          end
        end
        CONV_SUB: begin
          busy_q <= 1'b1;
          if (step_q == 3'd6) begin
            sub_bcd_q <= dab_s[14:7];
            step_q    <= 3'd0;
            state_q   <= COMMIT;
          end else begin
            sh_q      <= dab_s;
            step_q    <= step_q + 3'd1;
          end
        end
        COMMIT: begin
          disp_q <= {main_bcd_q, sub_bcd_q};
          mcol_q <= work_mc_q;
          scol_q <= work_sc_q;
          step_q <= 3'd0;
          // A Load landing on this cycle is newer than any shadow, so it goes next.
          if (Load) begin
            sh_q       <= {8'd0, sat99(MainTime)};
            work_sub_q <= sat99(SubTime);
            work_mc_q  <= MainColor;
            work_sc_q  <= SubColor;
            pending_q  <= 1'b0;
            state_q    <= CONV_MAIN;
            busy_q     <= 1'b1;
          end else if (pending_q) begin
            sh_q       <= {8'd0, shd_main_q};
            work_sub_q <= shd_sub_q;
            work_mc_q  <= shd_mc_q;
            work_sc_q  <= shd_sc_q;
            pending_q  <= 1'b0;
            state_q    <= CONV_MAIN;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign MainLed = mled_q;
  assign SubLed  = sled_q;
  assign Busy    = busy_q;

endmodule

// File: doc/module_display.md
MODULE_DISPLAY -- requirements
Module: module_display

Interface
REQ-001 Parameter SCAN_DIV, default 4: clocks each digit stays enabled; legal values are 1 or greater.
REQ-002 Parameter BLINK_DIV, default 5: clocks per half-period of the ONLINE blink; legal values are 1 or greater.
REQ-003 Parameters REDL=1, GREENL=2, YELLOWL=3, ONLINEL=4: colour codes on the MainColor/SubColor inputs.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port Load, input, 1: strobe; samples MainTime, SubTime, MainColor and SubColor.
REQ-007 Port MainTime, input, 16: main-road remaining seconds, unsigned.
REQ-008 Port SubTime, input, 16: sub-road remaining seconds, unsigned.
REQ-009 Port MainColor, input, 8: main-road colour code.
REQ-010 Port SubColor, input, 8: sub-road colour code.
REQ-011 Port seg, output, 7: segment drive, active-low, bit order gfedcba.
REQ-012 Port an, output, 4: digit enables, active-low; an[3]=main tens, an[2]=main ones, an[1]=sub tens, an[0]=sub ones.
REQ-013 Port MainLed, output, 3: main-road lamps, one-hot, bit2=red, bit1=yellow, bit0=green.
REQ-014 Port SubLed, output, 3: sub-road lamps, same encoding as MainLed.
REQ-015 Port Busy, output, 1: high while a conversion is in progress.

Function
REQ-016 The FSM SHALL have the states IDLE, CONV_MAIN, CONV_SUB and COMMIT.
REQ-017 In IDLE, Load=1 SHALL capture all four inputs and move to CONV_MAIN on the next cycle.
- Each captured time SHALL be saturated to 99 before conversion.
REQ-018 CONV_MAIN SHALL run a 7-step shift-add-3 binary-to-BCD conversion, one bit per cycle (7 cycles), then move to CONV_SUB.
REQ-019 CONV_SUB SHALL convert the sub-road time the same way (7 cycles), then move to COMMIT.
REQ-020 COMMIT SHALL last 1 cycle and atomically update all four displayed BCD digits, MainLed and SubLed.
- New values SHALL be visible 16 cycles after the Load edge.
REQ-021 Busy SHALL be 1 in CONV_MAIN, CONV_SUB and COMMIT, and 0 in IDLE.
REQ-022 A Load while Busy=1 SHALL overwrite a shadow capture and set a pending flag; only the latest such Load SHALL be kept.
REQ-023 At COMMIT with pending=1, the FSM SHALL clear pending, adopt the shadow, and go directly to CONV_MAIN; with pending=0 it SHALL go to IDLE.
REQ-024 A Load in the same cycle as COMMIT SHALL be treated as pending: the committed data is shown and the new data is converted next.
REQ-025 A free-running scan counter SHALL advance the digit index every SCAN_DIV cycles in the order 3,2,1,0,3,…
- Exactly one bit of an SHALL be low at any time.
REQ-026 seg SHALL carry the standard 0–9 pattern of the selected digit.
- A tens digit equal to 0 SHALL be blanked (seg=7'h7F).
REQ-027 Colour codes 1, 2 and 3 SHALL light red, green and yellow respectively.
- Code 4 SHALL light yellow only while blink phase=1.
- Any other code SHALL turn all three lamps off.
REQ-028 The blink phase SHALL toggle every BLINK_DIV cycles, free-running, independent of Load.
REQ-029 Displayed digits and lamps SHALL hold their last committed values between COMMITs.

Reset
REQ-030 rst=1 SHALL, on the next clock edge, override every other input, including mid-conversion.
REQ-031 Reset SHALL set:
- FSM = IDLE, pending = 0, Busy = 0;
- all displayed digits = 0, MainLed = SubLed = 3'b000;
- scan index = 3, scan counter = 0, blink phase = 0, blink counter = 0;
- an = 4'b0111, seg = 7'h7F.

Verification
REQ-032 Load with MainTime=18, SubTime=18, MainColor=1, SubColor=1 -> after 16 cycles the main and sub digits read 1,8 and 1,8, MainLed=SubLed=3'b100, and Busy was high for exactly 15 cycles.
REQ-033 Load with MainTime=300, SubTime=7, MainColor=2, SubColor=3 -> main shows 99, sub shows a blank tens digit then 7, MainLed=001, SubLed=010.
REQ-034 Load MainTime=5; 3 cycles later Load MainTime=12; then Load MainTime=40 -> only 40 is displayed after the second conversion, and 5 is shown in between.
REQ-035 Load MainColor=4 -> MainLed alternates 010/000 every 5 cycles; with MainColor=9, MainLed stays 000.
REQ-036 Assert rst during CONV_SUB -> Busy=0 and the digits read 0 on the next cycle; the prior in-flight Load is never displayed.
REQ-037 Free-running scan with SCAN_DIV=4 -> an cycles 0111, 1011, 1101, 1110, each held for 4 cycles, and exactly one bit is low at all times.
